// File: rtl/cpu_mem_responder_if.sv
// rtl/cpu_mem_responder_if.sv - data-memory request/response bundle between CPU and responder
interface cpu_mem_responder_if;
  logic        mRD;
  logic        mWR;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output mRD, mWR, addr, wdata, input busy, ack, rdata, err);
  modport slave  (input mRD, mWR, addr, wdata, output busy, ack, rdata, err);
endinterface

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - fixed-latency word memory responder; CPU_MEM_ALIGN_CHECK_EN enables misalignment errors
module cpu_mem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                reset,
  cpu_mem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state, state_nxt;
  logic                    accept, complete, aligned;
  logic [3:0]              cnt;
  logic                    wr_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic                    ack_q;
  logic [31:0]             mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: if (bus.mRD || bus.mWR) begin
        accept    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (cnt == 4'd0) begin
        complete  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured only at accept so later bus activity cannot disturb the access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ack_q <= complete;
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        wr_q    <= bus.mWR;
        idx_q   <= bus.addr[DEPTH_LOG2+1:2];
        wdata_q <= bus.wdata;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (complete && aligned) begin
        if (wr_q) mem[idx_q] <= wdata_q;
        else      rdata_q    <= mem[idx_q];
      end
    end
  end

`ifdef CPU_MEM_ALIGN_CHECK_EN
  logic [1:0] low_q;
  logic       err_q;
  logic       unused_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      low_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) low_q <= bus.addr[1:0];
      err_q <= complete && !aligned;
    end
  end

  assign aligned     = (low_q == 2'b00);
  assign bus.err     = err_q;
  assign unused_addr = ^bus.addr[31:DEPTH_LOG2+2];
`else
  logic unused_addr;

  assign aligned     = 1'b1;
  assign bus.err     = 1'b0;
  assign unused_addr = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};
`endif

  assign bus.busy  = (state == WAIT);
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - directed self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   n;

  cpu_mem_responder_if bus ();

  cpu_mem_responder #(.DEPTH_LOG2(6), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the bus after accept, and return in the ack cycle.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d, input string tag);
    int k;
    bus.mWR = wr; bus.mRD = !wr; bus.addr = a; bus.wdata = d;
    step();
    bus.mWR = 1'b0; bus.mRD = 1'b0; bus.addr = ~a; bus.wdata = ~d;
    k = 0;
    while (!bus.ack && k < 20) begin
      step();
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(LATENCY));
  endtask

  task automatic count_acks(input int cycles, output int acks);
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.ack) acks++;
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.mRD = 1'b0; bus.mWR = 1'b0; bus.addr = '0; bus.wdata = '0;
    step(); step();
    reset = 1'b1;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset ack", {31'd0, bus.ack}, 32'd0);
    chk("reset err", {31'd0, bus.err}, 32'd0);
    chk("reset rdata", bus.rdata, 32'd0);
    count_acks(10, n);
    chk("idle acks", 32'(n), 32'd0);

    // Write 0x10 with cycle-by-cycle timing checks
    bus.mWR = 1'b1; bus.addr = 32'h10; bus.wdata = 32'hDEADBEEF;
    step();
    bus.mWR = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    chk("wr N busy", {31'd0, bus.busy}, 32'd1);
    chk("wr N ack", {31'd0, bus.ack}, 32'd0);
    step();
    chk("wr N+1 busy", {31'd0, bus.busy}, 32'd1);
    chk("wr N+1 ack", {31'd0, bus.ack}, 32'd0);
    step();
    chk("wr N+2 ack", {31'd0, bus.ack}, 32'd1);
    chk("wr N+2 busy", {31'd0, bus.busy}, 32'd0);
    chk("wr N+2 err", {31'd0, bus.err}, 32'd0);

    // Read issued while ack=1 (back-to-back)
    access(1'b0, 32'h10, 32'h0, "rd 0x10");
    chk("rd 0x10 data", bus.rdata, 32'hDEADBEEF);
    step();
    chk("ack one cycle", {31'd0, bus.ack}, 32'd0);

    // Aliasing; rdata must hold across the write
    access(1'b1, 32'h104, 32'h12345678, "wr 0x104");
    chk("rdata hold", bus.rdata, 32'hDEADBEEF);
    access(1'b0, 32'h004, 32'h0, "rd 0x004");
    chk("alias data", bus.rdata, 32'h12345678);
    step();

    // Write strobe held during busy is ignored
    bus.mRD = 1'b1; bus.addr = 32'h20;
    step();
    bus.mRD = 1'b0; bus.mWR = 1'b1; bus.wdata = 32'hFFFFFFFF;
    step();
    chk("ign N+1 ack", {31'd0, bus.ack}, 32'd0);
    step();
    chk("ign N+2 ack", {31'd0, bus.ack}, 32'd1);
    chk("ign rdata", bus.rdata, 32'h0);
    bus.mWR = 1'b0;
    count_acks(5, n);
    chk("ign extra acks", 32'(n), 32'd0);
    access(1'b0, 32'h20, 32'h0, "rd 0x20");
    chk("ign mem", bus.rdata, 32'h0);
    step();

    // Reset one edge after accepting a write
    bus.mWR = 1'b1; bus.addr = 32'h30; bus.wdata = 32'hA5A5A5A5;
    step();
    bus.mWR = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst rdata", bus.rdata, 32'h0);
    count_acks(5, n);
    chk("rst acks", 32'(n), 32'd0);
    access(1'b0, 32'h30, 32'h0, "rd 0x30");
    chk("rst mem 0x30", bus.rdata, 32'h0);
    access(1'b0, 32'h10, 32'h0, "rd 0x10 post");
    chk("rst mem 0x10", bus.rdata, 32'h0);
    step();

    // Misaligned write
    access(1'b1, 32'h42, 32'h1, "wr 0x42");
`ifdef CPU_MEM_ALIGN_CHECK_EN
    chk("mis err", {31'd0, bus.err}, 32'd1);
    step();
    chk("mis err clear", {31'd0, bus.err}, 32'd0);
    access(1'b0, 32'h40, 32'h0, "rd 0x40");
    chk("mis mem", bus.rdata, 32'h0);
`else
    chk("mis err", {31'd0, bus.err}, 32'd0);
    step();
    access(1'b0, 32'h40, 32'h0, "rd 0x40");
    chk("mis mem", bus.rdata, 32'h1);
`endif
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
